// File: rtl/freq_period_meter.sv
// rtl/freq_period_meter.sv - measures period of an async input in clkin cycles and flags lock
// Optional macro DUTY_MEAS_EN adds the synchronized high-time measurement on high_time.
module freq_period_meter #(
   parameter int CNT_W    = 16,
   parameter int LOCK_CNT = 4,
   parameter int TOL      = 1
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             en,
   input  logic             sigin,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             locked,
`ifdef DUTY_MEAS_EN
   output logic [CNT_W-1:0] high_time,
`endif
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CNT);
   localparam logic [CNT_W:0]   TOL_V    = (CNT_W+1)'(TOL);

   state_t           state, state_nxt;
   logic             s1, s2, s3, edge_p;
   logic [CNT_W-1:0] cnt, prev;
   logic             have_prev;
   logic [3:0]       streak, streak_inc;
   logic [CNT_W:0]   diff;
   logic             match, sat;

   assign edge_p     = s2 & ~s3;
   // an edge arriving on the saturation cycle still completes a normal measurement
   assign sat        = (cnt == CNT_MAX) & ~edge_p;
   assign diff       = (cnt >= prev) ? ({1'b0, cnt} - {1'b0, prev}) : ({1'b0, prev} - {1'b0, cnt});
   assign match      = (diff <= TOL_V);
   assign streak_inc = (streak == LOCK_MAX) ? streak : streak + 4'd1;

   always_ff @(posedge clkin) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = ARM;
            ARM:     if (edge_p) state_nxt = MEAS;
            MEAS:    if (sat) state_nxt = ARM;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
         cnt        <= '0;
         prev       <= '0;
         have_prev  <= 1'b0;
         streak     <= '0;
         period     <= '0;
         period_vld <= 1'b0;
         locked     <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         s1         <= sigin;
         s2         <= s1;
         s3         <= s2;
         period_vld <= 1'b0;
         if (!en) begin
            cnt    <= '0;
            streak <= '0;
            locked <= 1'b0;
         end else begin
            case (state)
               ARM: begin
                  if (edge_p) begin
                     cnt       <= CNT_W'(1);
                     overflow  <= 1'b0;
                     streak    <= '0;
                     have_prev <= 1'b0;
                  end else begin
                     cnt <= '0;
                  end
               end
               MEAS: begin
                  if (edge_p) begin
                     period     <= cnt;
                     period_vld <= 1'b1;
                     cnt        <= CNT_W'(1);
                     prev       <= cnt;
                     have_prev  <= 1'b1;
                     // first period after arming only seeds the comparison
                     if (have_prev) begin
                        if (match) begin
                           streak <= streak_inc;
                           if (streak_inc == LOCK_MAX) locked <= 1'b1;
                        end else begin
                           streak <= '0;
                           locked <= 1'b0;
                        end
                     end
                  end else if (sat) begin
                     overflow <= 1'b1;
                     locked   <= 1'b0;
                     streak   <= '0;
                     cnt      <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: cnt <= '0;
            endcase
         end
      end
   end

`ifdef DUTY_MEAS_EN
   logic [CNT_W-1:0] hcnt;

   always_ff @(posedge clkin) begin
      if (rst) begin
         hcnt      <= '0;
         high_time <= '0;
      end else begin
         if (edge_p)                       hcnt <= CNT_W'(1);
         else if (s2 && (hcnt != CNT_MAX)) hcnt <= hcnt + 1'b1;
         if (s3 && !s2) high_time <= hcnt;
      end
   end
`endif

endmodule

// File: tb/tb_freq_period_meter.sv
// tb/tb_freq_period_meter.sv - scoreboard bench for freq_period_meter
module tb_freq_period_meter;

   localparam int CNT_W    = 8;
   localparam int LOCK_CNT = 4;
   localparam int TOL      = 1;
   localparam int MAXP     = (1 << CNT_W) - 1;

   logic             clkin = 1'b0;
   logic             rst   = 1'b1;
   logic             en    = 1'b0;
   logic             sigin = 1'b0;
   logic [CNT_W-1:0] period;
   logic             period_vld, locked, overflow;
`ifdef DUTY_MEAS_EN
   logic [CNT_W-1:0] high_time;
`endif

   freq_period_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TOL(TOL)) dut (
      .clkin      (clkin),
      .rst        (rst),
      .en         (en),
      .sigin      (sigin),
      .period     (period),
      .period_vld (period_vld),
      .locked     (locked),
`ifdef DUTY_MEAS_EN
      .high_time  (high_time),
`endif
      .overflow   (overflow)
   );

   always #5 clkin = ~clkin;

   int cyc = 0;
   always @(posedge clkin) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model: tracks rising times of sigin and applies the measurement rules
   typedef struct {
      int   p;
      logic lk;
      logic ov;
   } exp_t;
   exp_t q[$];

   logic m_en, m_meas, m_have_prev, m_locked, m_ov;
   int   m_prev, m_streak, m_last, m_period;

   function automatic void m_reset();
      m_meas = 0; m_have_prev = 0; m_locked = 0; m_ov = 0;
      m_prev = 0; m_streak = 0; m_last = 0; m_period = 0;
      q.delete();
   endfunction

   function automatic void m_overflow();
      m_ov = 1; m_locked = 0; m_streak = 0; m_meas = 0;
   endfunction

   function automatic void m_disable();
      m_en = 0; m_meas = 0; m_locked = 0; m_streak = 0;
   endfunction

   function automatic void m_gap(int c);
      if (m_en && m_meas && (c - m_last > MAXP + 3)) m_overflow();
   endfunction

   function automatic void m_rise(int c);
      int p, d;
      if (!m_en) return;
      if (m_meas && (c - m_last > MAXP)) m_overflow();
      if (!m_meas) begin
         m_meas = 1; m_have_prev = 0; m_streak = 0; m_ov = 0;
      end else begin
         p = c - m_last;
         if (m_have_prev) begin
            d = (p > m_prev) ? p - m_prev : m_prev - p;
            if (d <= TOL) begin
               if (m_streak < LOCK_CNT) m_streak++;
               if (m_streak == LOCK_CNT) m_locked = 1;
            end else begin
               m_streak = 0; m_locked = 0;
            end
         end
         m_have_prev = 1;
         m_prev = p;
         m_period = p;
         q.push_back('{p, m_locked, m_ov});
      end
      m_last = c;
   endfunction

   // monitor: every strobe must match the oldest expected measurement
   logic vld_d = 1'b0;
   always @(negedge clkin) begin
      exp_t e;
      if (!rst && period_vld) begin
         chk("vld_spacing", vld_d, 0);
         if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_strobe: got period %0d expected no strobe (cycle %0d)", period, cyc);
         end else begin
            e = q.pop_front();
            chk("strobe_period", period, e.p);
            chk("strobe_locked", locked, e.lk);
            chk("strobe_overflow", overflow, e.ov);
         end
      end
      vld_d <= period_vld;
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clkin);
         #1;
      end
   endtask

   task automatic rise();
      sigin = 1'b1;
      m_rise(cyc);
   endtask

   task automatic pulse(int hi, int lo);
      rise();
      tick(hi);
      sigin = 1'b0;
      tick(lo);
   endtask

   task automatic restart();
      en = 1'b0;
      m_disable();
      tick(3);
      en = 1'b1;
      m_en = 1;
      tick(5);
   endtask

   initial begin
      int base, p, hi;
      m_en = 0;
      m_reset();

      // reset and idle
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_period", period, 0);
      chk("rst_vld", period_vld, 0);
      chk("rst_locked", locked, 0);
      chk("rst_overflow", overflow, 0);
      for (int i = 0; i < 5; i++) pulse($urandom_range(2, 8), $urandom_range(2, 8));
      tick(4);
      chk("idle_period", period, m_period);
      chk("idle_locked", locked, m_locked);
      chk("idle_overflow", overflow, m_ov);

      // steady 36-cycle ratio
      en = 1'b1;
      m_en = 1;
      tick(5);
      repeat (6) pulse(18, 18);
      chk("steady_locked", locked, m_locked);
      chk("steady_period", period, 36);
`ifdef DUTY_MEAS_EN
      chk("steady_high_time", high_time, 18);
`endif

      // tolerance: 36,37,36,38 then relock, then a single mismatch
      restart();
      pulse(18, 18);
      pulse(18, 19);
      pulse(18, 18);
      pulse(19, 19);
      pulse(18, 18);
      chk("tol_locked", locked, m_locked);
      repeat (6) pulse(18, 18);
      chk("tol_relock", locked, m_locked);
      pulse(25, 25);
      pulse(18, 18);
      chk("tol_unlock", locked, m_locked);

      // randomized ratios with small jitter
      restart();
      base = 30;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) base = $urandom_range(8, 120);
         p  = base + $urandom_range(0, 2);
         hi = $urandom_range(2, p - 2);
         pulse(hi, p - hi);
      end
      chk("rand_locked", locked, m_locked);

      // overflow, saturation boundary, recovery
      restart();
      rise();
      tick(10);
      sigin = 1'b0;
      tick(290);
      m_gap(cyc);
      chk("ovf_set", overflow, m_ov);
      chk("ovf_locked", locked, m_locked);
      pulse(10, 10);
      pulse(100, 155);
      pulse(100, 156);
      pulse(10, 10);
      pulse(10, 10);
      chk("ovf_cleared", overflow, m_ov);

      // disable mid-measurement
      restart();
      repeat (6) pulse(12, 12);
      chk("dis_pre_locked", locked, m_locked);
      rise();
      tick(10);
      en = 1'b0;
      m_disable();
      tick(4);
      sigin = 1'b0;
      tick(10);
      chk("dis_locked", locked, m_locked);
      chk("dis_period_hold", period, m_period);
      repeat (3) pulse(12, 12);
      en = 1'b1;
      m_en = 1;
      tick(5);
      pulse(12, 12);
      pulse(14, 14);
      pulse(12, 12);
      chk("reen_period", period, m_period);

      // reset while locked
      repeat (8) pulse(15, 15);
      chk("rstm_pre_locked", locked, m_locked);
      rise();
      tick(8);
      sigin = 1'b0;
      tick(4);
      rst = 1'b1;
      tick(1);
      chk("rstm_period", period, 0);
      chk("rstm_vld", period_vld, 0);
      chk("rstm_locked", locked, 0);
      chk("rstm_overflow", overflow, 0);
`ifdef DUTY_MEAS_EN
      chk("rstm_high_time", high_time, 0);
`endif
      m_reset();
      rst = 1'b0;
      tick(5);
      repeat (7) pulse(10, 11);
      chk("post_rst_locked", locked, m_locked);

      tick(10);
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
